rand_byte_serializer: RTL and testbench

- Sits directly downstream of the clk3-domain FIFO reader, in the same clock domain.
- Consumes its burst stream of 32-bit random words, which is valid-only with no backpressure.
- Buffers the words in a small synchronous FIFO and emits them as an MSB-first byte stream on a valid/ready interface.
- Marks the last byte of each frame and flags any words it had to drop.

---
 rtl/rand_ser_pkg.sv | 15 +
 rtl/sync_word_fifo.sv | 47 ++++
 rtl/rand_byte_serializer.sv | 126 ++++++++++++
 tb/tb_rand_byte_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_ser_pkg.sv
// Shared types and defaults for the random-word byte serializer.
package rand_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  localparam int BYTE_IDX_W      = 2;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_FRAME_WORDS = 256;

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(3);

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with extra-MSB binary pointers and a combinational head word.
module sync_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign count  = wrPtr_q - rdPtr_q;
  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (count == (AW+1)'(DEPTH));
  assign rdata  = mem_q[rdPtr_q[AW-1:0]];
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign doPush = push && (!full || pop);
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rand_byte_serializer.sv
// Buffers a valid-only 32-bit word stream and emits it MSB-first as a valid/ready
// byte stream, marking frame ends and flagging dropped words.
module rand_byte_serializer
  import rand_ser_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);

  ser_state_e            state_q;
  logic [31:0]           shiftReg_q;
  logic [BYTE_IDX_W-1:0] byteIdx_q;
  logic [WC_W-1:0]       wordCnt_q;
  logic [WC_W-1:0]       wordCnt_d;
  logic                  outValid_q;
  logic [7:0]            outData_q;
  logic                  outLast_q;
  logic                  overflow_q;
  logic                  frameDone_q;

  logic                  byteHs;
  logic                  lastByteHs;
  logic                  frameEnd;
  logic                  wordPop;
  logic                  fifoPush;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [31:0]           headWord;

  assign byteHs     = outValid_q && out_ready;
  assign lastByteHs = byteHs && (byteIdx_q == LAST_BYTE);
  assign frameEnd   = lastByteHs && (wordCnt_q == LAST_WORD);
  // out_valid is low exactly in IDLE, so the IDLE load and the back-to-back reload share one term.
  assign wordPop    = !fifoEmpty && ((state_q == IDLE) || lastByteHs);
  assign fifoPush   = in_valid && (!fifoFull || wordPop);
  assign wordCnt_d  = frameEnd ? '0 : wordCnt_q + 1'b1;

  sync_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifoPush),
    .pop   (wordPop),
    .wdata (in_data),
    .rdata (headWord),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shiftReg_q  <= '0;
      byteIdx_q   <= '0;
      wordCnt_q   <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
      overflow_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= frameEnd;
      if (in_valid && fifoFull && !wordPop) overflow_q <= 1'b1;
      if (lastByteHs) wordCnt_q <= wordCnt_d;

      case (state_q)
        IDLE: begin
          if (wordPop) begin
            shiftReg_q <= headWord;
            outData_q  <= headWord[31:24];
            byteIdx_q  <= '0;
            outValid_q <= 1'b1;
            outLast_q  <= 1'b0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (lastByteHs) begin
            if (wordPop) begin
              shiftReg_q <= headWord;
              outData_q  <= headWord[31:24];
              byteIdx_q  <= '0;
              outLast_q  <= 1'b0;
            end else begin
              outValid_q <= 1'b0;
              outLast_q  <= 1'b0;
              state_q    <= IDLE;
            end
          end else if (byteHs) begin
            byteIdx_q  <= byteIdx_q + 1'b1;
            outData_q  <= shiftReg_q[23:16];
            shiftReg_q <= {shiftReg_q[23:0], 8'h00};
            // Byte 3 of the frame's final word is about to be presented.
            outLast_q  <= (byteIdx_q == BYTE_IDX_W'(2)) && (wordCnt_q == LAST_WORD);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_last   = outLast_q;
  assign overflow   = overflow_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_rand_byte_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_rand_byte_serializer;

  localparam int DEPTH = 8;
  localparam int FW    = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic        overflow;
  logic        frame_done;

  rand_byte_serializer #(
    .DEPTH       (DEPTH),
    .FRAME_WORDS (FW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_cnt   (fifo_cnt),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;
  int failCnt  = 0;

  // Reference model: buffered words, the word being sent, and the byte scoreboard.
  logic [31:0] mQ[$];
  logic [7:0]  expB[$];
  logic        mValid;
  logic [31:0] mCur;
  int          mIdx;
  logic [7:0]  mData;
  int          mWc;
  logic        mOvf;
  logic        mDone;

  int hsCount, lastHits, lastAt, doneHits, doneAt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt += 1;
    assert (obs === exp) passCnt += 1;
    else begin
      failCnt += 1;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    expB.delete();
    mValid = 1'b0;
    mCur   = '0;
    mIdx   = 0;
    mData  = '0;
    mWc    = 0;
    mOvf   = 1'b0;
    mDone  = 1'b0;
  endtask

  task automatic checkOutput();
    check("out_valid", out_valid, mValid);
    if (mValid) check("out_data", out_data, mData);
    check("out_last", out_last, mValid && (mIdx == 3) && (mWc == FW - 1));
    check("fifo_cnt", fifo_cnt, mQ.size());
    check("overflow", overflow, mOvf);
    check("frame_done", frame_done, mDone);
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check 1ns later.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    logic       preV, preL, hs, lastHs, pop, accept;
    logic [7:0] preD;
    logic [7:0] expByte;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    preV = out_valid;
    preD = out_data;
    preL = out_last;
    @(posedge clk);
    if (preV && r) begin
      hsCount += 1;
      if (preL) begin
        lastHits += 1;
        lastAt = hsCount;
      end
      if (expB.size() == 0) check("stream_extra_byte", 1, 0);
      else begin
        expByte = expB.pop_front();
        check("stream_byte", preD, expByte);
      end
    end
    hs     = mValid && r;
    lastHs = hs && (mIdx == 3);
    pop    = (mQ.size() > 0) && (!mValid || lastHs);
    accept = v && ((mQ.size() < DEPTH) || pop);
    mDone  = lastHs && (mWc == FW - 1);
    if (lastHs) mWc = (mWc + 1) % FW;
    if (pop) begin
      mCur   = mQ.pop_front();
      mIdx   = 0;
      mValid = 1'b1;
      mData  = mCur[31:24];
    end else if (lastHs) begin
      mValid = 1'b0;
    end else if (hs) begin
      mIdx  = mIdx + 1;
      mData = mCur[31 - 8*mIdx -: 8];
    end
    if (accept) begin
      mQ.push_back(d);
      for (int b = 3; b >= 0; b--) expB.push_back(d[8*b +: 8]);
    end else if (v) begin
      mOvf = 1'b1;
    end
    #1;
    checkOutput();
    if (frame_done) begin
      doneHits += 1;
      doneAt = hsCount;
    end
    @(negedge clk);
  endtask

  task automatic resetPulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_fifo_cnt"}, fifo_cnt, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    modelReset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    int          base;
    modelReset();
    hsCount = 0; lastHits = 0; lastAt = -1; doneHits = 0; doneAt = -1;
    @(negedge clk);
    resetPulse("reset");

    // Single word: two edges from assertion to byte 0, then four consecutive bytes.
    w = 32'h12345678;
    applyStimulus(1'b1, w, 1'b1);
    check("single_lat_edge1", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      check("single_valid", out_valid, 1);
      check("single_byte", out_data, w[31 - 8*i -: 8]);
      check("single_last", out_last, 0);
    end
    applyStimulus(1'b0, '0, 1'b1);
    check("single_idle", out_valid, 0);
    check("single_cnt", fifo_cnt, 0);

    // Backpressure: byte 0 must hold while stalled, then each byte appears once.
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0);
    check("bp_hold", out_data, 8'hA1);
    base = hsCount;
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    check("bp_bytes", hsCount - base, 4);
    check("bp_drained", expB.size(), 0);

    // Full FIFO with a word arriving on the same edge as the byte-3 handshake.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'hC0DE0000 + i, 1'b0);
    check("fullpop_pre_cnt", fifo_cnt, 8);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'hFEEDBEEF, 1'b1);
    check("fullpop_cnt", fifo_cnt, 8);
    check("fullpop_ovf", overflow, 0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, 1'b1);
    check("fullpop_drained", expB.size(), 0);

    // Overflow: 12-word burst into a stalled output, three words dropped.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'h0B0B0000 + i, 1'b0);
      if (i == 8) begin
        check("ovf_full_cnt", fifo_cnt, 8);
        check("ovf_not_yet", overflow, 0);
      end
      if (i == 9) check("ovf_set", overflow, 1);
    end
    base = hsCount;
    for (int i = 0; i < 45; i++) applyStimulus(1'b0, '0, 1'b1);
    check("ovf_bytes", hsCount - base, 36);
    check("ovf_sticky", overflow, 1);
    check("ovf_idle", out_valid, 0);

    resetPulse("reset2");

    // Frame: 257 words, one every four cycles, output always ready.
    base = hsCount; lastHits = 0; lastAt = -1; doneHits = 0; doneAt = -1;
    for (int i = 0; i < FW + 1; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1);
      for (int j = 0; j < 3; j++) applyStimulus(1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);
    check("frame_bytes", hsCount - base, 4 * (FW + 1));
    check("frame_last_hits", lastHits, 1);
    check("frame_last_pos", lastAt - base, 4 * FW);
    check("frame_done_hits", doneHits, 1);
    check("frame_done_at", doneAt, lastAt);

    resetPulse("reset3");

    // Random traffic against the model and scoreboard.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 9) < 7));
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, '0, 1'b1);
    check("rand_drained", expB.size(), 0);

    // Reset mid-word with three words buffered.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h5EED0000 + i, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    check("midrst_cnt_pre", fifo_cnt, 3);
    resetPulse("midrst");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);
    check("midrst_quiet", out_valid, 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
